// File: rtl/conv_bias_sequencer_if.sv
// Stream/bus bundle between the conv accumulator source, the bias selector and the next layer.
// The master side is the sequencer; the slave side is its environment.
interface conv_bias_sequencer_if #(
    parameter int unsigned ACC_W  = 22,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned NUM_CH = 8
);
    logic [NUM_CH*ACC_W-1:0] Acc_i;
    logic                    AccValid_i;
    logic                    AccReady_o;
    logic [2:0]              BiasSel_o;
    logic signed [21:0]      Bias_i;
    logic [OUT_W-1:0]        Out_o;
    logic [2:0]              OutCh_o;
    logic                    OutLast_o;
    logic                    OutValid_o;
    logic                    OutReady_i;

    modport master (
        input  Acc_i, AccValid_i, Bias_i, OutReady_i,
        output AccReady_o, BiasSel_o, Out_o, OutCh_o, OutLast_o, OutValid_o
    );

    modport slave (
        output Acc_i, AccValid_i, Bias_i, OutReady_i,
        input  AccReady_o, BiasSel_o, Out_o, OutCh_o, OutLast_o, OutValid_o
    );
endinterface

// File: rtl/conv_bias_sequencer.sv
// Walks one captured frame of conv accumulators through the bias selector, applies
// bias + ReLU + shift + saturate, and streams one activation per channel.
module conv_bias_sequencer #(
    parameter int unsigned ACC_W  = 22,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 6,
    parameter int unsigned NUM_CH = 8
) (
    input  logic                   Clk_i,
    input  logic                   Rst_i,
    conv_bias_sequencer_if.master  bus
);
    localparam int unsigned BIAS_W = 22;
    localparam int unsigned W      = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;
    localparam logic [2:0]  LAST_CH = 3'(NUM_CH - 1);
    localparam logic [W-1:0] OUT_MAX = W'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               ch_q, ch_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_CH];
    logic signed [ACC_W-1:0]  acc_d [NUM_CH];
    logic [OUT_W-1:0]         out_q, out_d;
    logic [2:0]               out_ch_q, out_ch_d;
    logic                     out_last_q, out_last_d;
    logic                     out_valid_q, out_valid_d;

    logic                     acc_ready_c;
    logic                     load_c;
    logic signed [ACC_W-1:0]  acc_sel_c;
    logic signed [W-1:0]      sum_c;
    logic [W-1:0]             relu_c;
    logic [W-1:0]             sh_c;
    logic [OUT_W-1:0]         res_c;

    assign acc_ready_c = (state_q == IDLE) & ~Rst_i;
    assign load_c      = ~out_valid_q | bus.OutReady_i;

    // Bias add cannot overflow at W bits; saturate only the shifted positive value.
    always_comb begin
        acc_sel_c = acc_q[ch_q];
        sum_c     = W'(acc_sel_c) + W'(bus.Bias_i);
        relu_c    = sum_c[W-1] ? '0 : sum_c;
        sh_c      = relu_c >> SHIFT;
        res_c     = (sh_c > OUT_MAX) ? '1 : sh_c[OUT_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.AccValid_i && acc_ready_c) begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        acc_d[k] = bus.Acc_i[k*ACC_W +: ACC_W];
                    end
                    ch_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_c) begin
                    out_d       = res_c;
                    out_ch_d    = ch_q;
                    out_last_d  = (ch_q == LAST_CH);
                    out_valid_d = 1'b1;
                    if (ch_q == LAST_CH) begin
                        ch_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.OutReady_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Frame storage needs no reset; it is only read after a capture.
    always_ff @(posedge Clk_i) begin
        acc_q <= acc_d;
    end

    assign bus.AccReady_o = acc_ready_c;
    assign bus.BiasSel_o  = ch_q;
    assign bus.Out_o      = out_q;
    assign bus.OutCh_o    = out_ch_q;
    assign bus.OutLast_o  = out_last_q;
    assign bus.OutValid_o = out_valid_q;
endmodule

// File: tb/tb_conv_bias_sequencer.sv
// Directed bench for conv_bias_sequencer with a bias selector model returning 100*channel.
module tb_conv_bias_sequencer;
    localparam int unsigned ACC_W  = 22;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned SHIFT  = 6;
    localparam int unsigned NUM_CH = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lanes [8];
    int   exp_q [8];

    conv_bias_sequencer_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)) bus ();

    conv_bias_sequencer #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .NUM_CH(NUM_CH)) dut (
        .Clk_i (clk),
        .Rst_i (rst),
        .bus   (bus.master)
    );

    assign bus.Bias_i = 22'(int'(bus.BiasSel_o) * 100);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH*ACC_W-1:0] pack_lanes(input int l [8]);
        logic [NUM_CH*ACC_W-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*ACC_W +: ACC_W] = 22'(l[k]);
        return v;
    endfunction

    // Called at a negedge; offers a frame, then collects beats against exp_q.
    // mode 0: OutReady_i always 1; mode 1: ready pattern 1,0,0,1,0,1 repeating.
    task automatic run_frame(input string tag, input logic [NUM_CH*ACC_W-1:0] acc,
                             input logic [NUM_CH*ACC_W-1:0] acc_after, input logic valid_after,
                             input int mode, input int stop_after);
        int          waitc;
        int          idx;
        int          cyc;
        int          first_cyc;
        logic        hold_pend;
        logic [11:0] held;
        logic        rdy;
        waitc     = 0;
        idx       = 0;
        cyc       = 0;
        first_cyc = -1;
        hold_pend = 1'b0;
        held      = '0;
        bus.Acc_i      = acc;
        bus.AccValid_i = 1'b1;
        while (!bus.AccReady_o && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, " acc_ready_at_offer"}, 32'(bus.AccReady_o), 32'd1);
        @(negedge clk);
        bus.Acc_i      = acc_after;
        bus.AccValid_i = valid_after;
        chk({tag, " acc_ready_after_capture"}, 32'(bus.AccReady_o), 32'd0);
        while (idx < stop_after && cyc < 200) begin
            rdy = (mode == 0) || (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
            bus.OutReady_i = rdy;
            if (bus.OutValid_o) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (hold_pend)
                    chk({tag, " payload_stable"}, 32'({bus.Out_o, bus.OutCh_o, bus.OutLast_o}), 32'(held));
                chk({tag, " acc_ready_busy"}, 32'(bus.AccReady_o), 32'd0);
                if (rdy) begin
                    chk({tag, $sformatf(" out[%0d]", idx)}, 32'(bus.Out_o), 32'(exp_q[idx]));
                    chk({tag, $sformatf(" ch[%0d]", idx)}, 32'(bus.OutCh_o), 32'(idx));
                    chk({tag, $sformatf(" last[%0d]", idx)}, 32'(bus.OutLast_o), 32'(idx == 7));
                    idx++;
                    hold_pend = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    held      = {bus.Out_o, bus.OutCh_o, bus.OutLast_o};
                end
            end
            cyc++;
            @(negedge clk);
        end
        chk({tag, " beat_count"}, 32'(idx), 32'(stop_after));
        if (mode == 0) begin
            chk({tag, " first_beat_latency"}, 32'(first_cyc), 32'd1);
            if (stop_after == 8) chk({tag, " back_to_back"}, 32'(cyc), 32'd9);
        end
        if (idx == 8) begin
            chk({tag, " acc_ready_after_last"}, 32'(bus.AccReady_o), 32'd1);
            chk({tag, " valid_after_last"}, 32'(bus.OutValid_o), 32'd0);
        end
    endtask

    initial begin
        logic [NUM_CH*ACC_W-1:0] junk;
        logic [NUM_CH*ACC_W-1:0] frame_b;
        junk = {8{22'h2AAAAA}};
        rst            = 1'b1;
        bus.Acc_i      = '0;
        bus.AccValid_i = 1'b0;
        bus.OutReady_i = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst valid", 32'(bus.OutValid_o), 32'd0);
            chk("rst bias_sel", 32'(bus.BiasSel_o), 32'd0);
            chk("rst acc_ready", 32'(bus.AccReady_o), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst acc_ready", 32'(bus.AccReady_o), 32'd1);
        chk("post_rst valid", 32'(bus.OutValid_o), 32'd0);

        // Uniform lanes, continuous ready
        for (int k = 0; k < 8; k++) lanes[k] = 640;
        exp_q = '{10, 11, 13, 14, 16, 17, 19, 20};
        run_frame("t2", pack_lanes(lanes), junk, 1'b0, 0, 8);

        // ReLU, saturation and exact-zero cases
        lanes = '{-1000, 2097151, -200, 0, 0, 0, 0, 0};
        exp_q = '{0, 255, 0, 4, 6, 7, 9, 10};
        run_frame("t3", pack_lanes(lanes), junk, 1'b0, 0, 8);

        // Backpressure pattern
        for (int k = 0; k < 8; k++) lanes[k] = 640;
        exp_q = '{10, 11, 13, 14, 16, 17, 19, 20};
        run_frame("t4", pack_lanes(lanes), junk, 1'b0, 1, 8);

        // Reset after the ch3 handshake abandons the frame
        bus.OutReady_i = 1'b1;
        run_frame("t5a", pack_lanes(lanes), junk, 1'b0, 0, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 valid_in_rst", 32'(bus.OutValid_o), 32'd0);
        chk("t5 bias_sel_in_rst", 32'(bus.BiasSel_o), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5 no_stale_beat", 32'(bus.OutValid_o), 32'd0);
        end
        for (int k = 0; k < 8; k++) lanes[k] = 64;
        exp_q = '{1, 2, 4, 5, 7, 8, 10, 11};
        run_frame("t5b", pack_lanes(lanes), junk, 1'b0, 0, 8);

        // Back-to-back frames with AccValid_i held high
        for (int k = 0; k < 8; k++) lanes[k] = 1000 * k;
        frame_b = pack_lanes(lanes);
        for (int k = 0; k < 8; k++) lanes[k] = 640;
        exp_q = '{10, 11, 13, 14, 16, 17, 19, 20};
        run_frame("t6a", pack_lanes(lanes), frame_b, 1'b1, 0, 8);
        exp_q = '{0, 17, 34, 51, 68, 85, 103, 120};
        run_frame("t6b", frame_b, junk, 1'b0, 0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
